pal_file_loader: RTL and testbench

Loads a user-supplied NES palette file into the runtime-loadable palette RAM of the video output stage. It sits between the HPS ioctl download port and the video block's `load_color` write port. It converts a stream of RGB888 byte triplets into 64 BGR555 entries and issues one write strobe per completed entry. It reports whether the most recent download produced a complete palette.

---
 rtl/pal_file_loader.sv | 168 ++++++++++++++++
 tb/tb_pal_file_loader.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pal_file_loader.sv
// NES palette file loader: turns the ioctl RGB888 byte stream into 64 BGR555
// palette RAM writes and reports whether the latest download was complete.
module pal_file_loader #(
    parameter int ADDR_W = 25,
    parameter int ROUND  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              load_color,
    output logic [5:0]        load_color_index,
    output logic [14:0]       load_color_data,
    output logic              pal_loaded,
    output logic              pal_error
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FULL, S_ERR} state_t;
    typedef enum logic [1:0] {PH_R, PH_G, PH_B} phase_t;

    state_t      r_state,     w_state_nxt;
    phase_t      r_phase,     w_phase_nxt;
    logic [7:0]  r_exp_addr,  w_exp_addr_nxt;
    logic [6:0]  r_entry,     w_entry_nxt;
    logic [4:0]  r_red,       w_red_nxt;
    logic [4:0]  r_green,     w_green_nxt;
    logic        r_pend,      w_pend_nxt;
    logic        r_pend_last, w_pend_last_nxt;
    logic [5:0]  r_pend_idx,  w_pend_idx_nxt;
    logic [14:0] r_pend_data, w_pend_data_nxt;
    logic        r_loaded,    w_loaded_nxt;
    logic        r_error,     w_error_nxt;
    logic        r_dl_d;
    logic        r_load_color;
    logic [5:0]  r_index;
    logic [14:0] r_data;

    logic        w_rise;
    logic        w_fall;
    logic [4:0]  w_v5;

    function automatic logic [4:0] f_to5(input logic [7:0] d);
        logic [5:0] rounded;
        rounded = 6'(({1'b0, d} + 9'd4) >> 3);
        if (ROUND != 0)
            return rounded[5] ? 5'd31 : rounded[4:0];
        return d[7:3];
    endfunction

    assign w_v5   = f_to5(ioctl_dout);
    assign w_rise = ioctl_download & ~r_dl_d;
    assign w_fall = ~ioctl_download & r_dl_d;

    // NOTE: every variable gets a default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_exp_addr_nxt  = r_exp_addr;
        w_entry_nxt     = r_entry;
        w_red_nxt       = r_red;
        w_green_nxt     = r_green;
        w_pend_nxt      = 1'b0;
        w_pend_last_nxt = 1'b0;
        w_pend_idx_nxt  = r_pend_idx;
        w_pend_data_nxt = r_pend_data;
        w_loaded_nxt    = r_loaded | r_pend_last;
        w_error_nxt     = r_error;

        // A new download restarts from scratch; a byte arriving on the same
        // edge is then treated as offset 0 of that new download.
        if (w_rise) begin
            w_state_nxt    = S_COLLECT;
            w_phase_nxt    = PH_R;
            w_exp_addr_nxt = 8'd0;
            w_entry_nxt    = 7'd0;
            w_loaded_nxt   = 1'b0;
            w_error_nxt    = 1'b0;
        end else if (w_fall) begin
            if (r_state == S_COLLECT)
                w_error_nxt = 1'b1;
            w_state_nxt = S_IDLE;
        end

        if (w_state_nxt == S_COLLECT && ioctl_wr && ioctl_download) begin
            if (ioctl_addr != ADDR_W'(w_exp_addr_nxt)) begin
                w_error_nxt = 1'b1;
                w_state_nxt = S_ERR;
            end else begin
                w_exp_addr_nxt = w_exp_addr_nxt + 8'd1;
                case (w_phase_nxt)
                    PH_R: begin
                        w_red_nxt   = w_v5;
                        w_phase_nxt = PH_G;
                    end
                    PH_G: begin
                        w_green_nxt = w_v5;
                        w_phase_nxt = PH_B;
                    end
                    default: begin
                        w_pend_nxt      = 1'b1;
                        w_pend_idx_nxt  = w_entry_nxt[5:0];
                        w_pend_data_nxt = {w_v5, w_green_nxt, w_red_nxt};
                        w_phase_nxt     = PH_R;
                        if (w_entry_nxt == 7'd63) begin
                            w_pend_last_nxt = 1'b1;
                            w_state_nxt     = S_FULL;
                        end
                        w_entry_nxt = w_entry_nxt + 7'd1;
                    end
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_phase      <= PH_R;
            r_exp_addr   <= 8'd0;
            r_entry      <= 7'd0;
            r_red        <= 5'd0;
            r_green      <= 5'd0;
            r_pend       <= 1'b0;
            r_pend_last  <= 1'b0;
            r_pend_idx   <= 6'd0;
            r_pend_data  <= 15'd0;
            r_loaded     <= 1'b0;
            r_error      <= 1'b0;
            r_dl_d       <= 1'b0;
            r_load_color <= 1'b0;
            r_index      <= 6'd0;
            r_data       <= 15'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_exp_addr   <= w_exp_addr_nxt;
            r_entry      <= w_entry_nxt;
            r_red        <= w_red_nxt;
            r_green      <= w_green_nxt;
            r_pend       <= w_pend_nxt;
            r_pend_last  <= w_pend_last_nxt;
            r_pend_idx   <= w_pend_idx_nxt;
            r_pend_data  <= w_pend_data_nxt;
            r_loaded     <= w_loaded_nxt;
            r_error      <= w_error_nxt;
            r_dl_d       <= ioctl_download;
            // The completed entry leaves one edge after its B byte; index and
            // data then hold until the next write.
            r_load_color <= r_pend;
            if (r_pend) begin
                r_index <= r_pend_idx;
                r_data  <= r_pend_data;
            end
        end
    end

    assign load_color       = r_load_color;
    assign load_color_index = r_index;
    assign load_color_data  = r_data;
    assign pal_loaded       = r_loaded;
    assign pal_error        = r_error;

endmodule

// File: tb/tb_pal_file_loader.sv
// Bench for pal_file_loader: rounding and truncating instances share one
// byte stream; strobes are compared with a file-level reference model.
module tb_pal_file_loader;

    localparam int ADDR_W = 25;

    logic              clk = 1'b0;
    logic              reset;
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              lc_r, lc_t, ld_r, ld_t, er_r, er_t;
    logic [5:0]        idx_r, idx_t;
    logic [14:0]       dat_r, dat_t;

    always #5 clk = ~clk;

    pal_file_loader #(.ADDR_W(ADDR_W), .ROUND(1)) u_round (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .load_color(lc_r), .load_color_index(idx_r), .load_color_data(dat_r),
        .pal_loaded(ld_r), .pal_error(er_r)
    );

    pal_file_loader #(.ADDR_W(ADDR_W), .ROUND(0)) u_trunc (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .load_color(lc_t), .load_color_index(idx_t), .load_color_data(dat_t),
        .pal_loaded(ld_t), .pal_error(er_t)
    );

    typedef struct packed {
        logic [5:0]  idx;
        logic [14:0] data;
    } strobe_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        d;
    } wr_t;

    typedef struct {
        logic [7:0]  r, g, b;
        logic [14:0] exp_round;
        logic [14:0] exp_trunc;
    } vec_t;

    int        n_tests = 0;
    int        n_fail  = 0;
    int        cyc     = 0;
    int        drive191_cyc = -1;
    int        last_pulse_cyc = -1;
    logic      prev_ld_r = 1'b0;
    strobe_t   got_r[$], got_t[$], exp_r[$], exp_t[$];
    wr_t       bq[$];
    bit        exp_loaded, exp_error;
    vec_t      vt[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (lc_r === 1'b1) begin
            got_r.push_back({idx_r, dat_r});
            if (idx_r == 6'd63) begin
                last_pulse_cyc = cyc;
                check("loaded_with_last", 32'(ld_r), 32'd1);
                check("loaded_before_last", 32'(prev_ld_r), 32'd0);
            end
        end
        if (lc_t === 1'b1)
            got_t.push_back({idx_t, dat_t});
        prev_ld_r = ld_r;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // Reference: 8-to-5 bit reduction and file-level interpretation.
    function automatic int v5(input int d, input bit rnd);
        int v;
        if (rnd) begin
            v = (d + 4) / 8;
            if (v > 31) v = 31;
        end else begin
            v = d / 8;
        end
        return v;
    endfunction

    function automatic logic [14:0] color(input int r, input int g, input int b, input bit rnd);
        return 15'((v5(b, rnd) << 10) | (v5(g, rnd) << 5) | v5(r, rnd));
    endfunction

    task automatic build_model();
        int expect_off = 0;
        int n = 0;
        bit ok = 1'b1;
        int rgb[3];
        strobe_t s;
        exp_r.delete();
        exp_t.delete();
        foreach (bq[i]) begin
            if (!ok || n == 64) continue;
            if (bq[i].addr != ADDR_W'(expect_off)) begin
                ok = 1'b0;
                continue;
            end
            rgb[expect_off % 3] = int'(bq[i].d);
            expect_off++;
            if (expect_off % 3 == 0) begin
                s.idx  = n[5:0];
                s.data = color(rgb[0], rgb[1], rgb[2], 1'b1);
                exp_r.push_back(s);
                s.data = color(rgb[0], rgb[1], rgb[2], 1'b0);
                exp_t.push_back(s);
                n++;
            end
        end
        exp_loaded = (n == 64);
        exp_error  = (n != 64);
    endtask

    task automatic make_file(input int nbytes);
        wr_t w;
        bq.delete();
        for (int i = 0; i < nbytes; i++) begin
            w.addr = ADDR_W'(i);
            w.d    = 8'($urandom);
            bq.push_back(w);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic play(input int max_gap, input int count);
        for (int i = 0; i < count; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = bq[i].addr;
            ioctl_dout = bq[i].d;
            if (bq[i].addr == ADDR_W'(191) && drive191_cyc < 0)
                drive191_cyc = cyc;
            tick(1);
            ioctl_wr = 1'b0;
            if (max_gap > 0)
                tick($urandom_range(0, max_gap));
        end
    endtask

    task automatic dl_end();
        ioctl_download = 1'b0;
        tick(3);
    endtask

    task automatic clear_got();
        got_r.delete();
        got_t.delete();
    endtask

    task automatic compare_run(input string name);
        build_model();
        check({name, " count_round"}, got_r.size(), exp_r.size());
        check({name, " count_trunc"}, got_t.size(), exp_t.size());
        for (int i = 0; i < exp_r.size() && i < got_r.size(); i++)
            check({name, " strobe_round"}, 32'(got_r[i]), 32'(exp_r[i]));
        for (int i = 0; i < exp_t.size() && i < got_t.size(); i++)
            check({name, " strobe_trunc"}, 32'(got_t[i]), 32'(exp_t[i]));
        check({name, " loaded_round"}, 32'(ld_r), 32'(exp_loaded));
        check({name, " error_round"},  32'(er_r), 32'(exp_error));
        check({name, " loaded_trunc"}, 32'(ld_t), 32'(exp_loaded));
        check({name, " error_trunc"},  32'(er_t), 32'(exp_error));
    endtask

    initial begin
        vt[0] = '{8'hFF, 8'h80, 8'h07, 15'h061F, 15'h021F};
        vt[1] = '{8'h00, 8'h00, 8'h00, 15'h0000, 15'h0000};
        vt[2] = '{8'hFB, 8'hFC, 8'h03, 15'h03FF, 15'h03FF};
        vt[3] = '{8'h04, 8'h0B, 8'h0C, 15'h0821, 15'h0420};
        vt[4] = '{8'h7B, 8'h7C, 8'hF3, 15'h7A0F, 15'h79EF};
        vt[5] = '{8'h08, 8'h10, 8'h18, 15'h0C41, 15'h0C41};

        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        tick(3);
        check("rst load_color", 32'(lc_r), 32'd0);
        check("rst index",      32'(idx_r), 32'd0);
        check("rst data",       32'(dat_r), 32'd0);
        check("rst loaded",     32'(ld_r), 32'd0);
        check("rst error",      32'(er_r), 32'd0);
        reset = 1'b0;
        tick(1);

        // Bytes without an active download must be ignored.
        make_file(6);
        play(0, 6);
        tick(3);
        check("no_download strobes", got_r.size(), 32'd0);

        // Table vectors in entries 0..5; first byte coincides with the rise.
        clear_got();
        make_file(192);
        foreach (vt[k]) begin
            bq[3*k].d   = vt[k].r;
            bq[3*k+1].d = vt[k].g;
            bq[3*k+2].d = vt[k].b;
        end
        ioctl_download = 1'b1;
        play(1, 192);
        tick(2);
        check("table loaded_mid", 32'(ld_r), 32'd1);
        check("table error_mid",  32'(er_r), 32'd0);
        foreach (vt[k]) begin
            if (got_r.size() > k && got_t.size() > k) begin
                check("table index",      32'(got_r[k].idx), 32'(k));
                check("table data_round", 32'(got_r[k].data), 32'(vt[k].exp_round));
                check("table data_trunc", 32'(got_t[k].data), 32'(vt[k].exp_trunc));
            end else begin
                check("table strobe_present", 32'd0, 32'd1);
            end
        end
        dl_end();
        compare_run("table");

        // 1536-byte file, one byte every cycle.
        clear_got();
        drive191_cyc   = -1;
        last_pulse_cyc = -1;
        make_file(1536);
        ioctl_download = 1'b1;
        play(0, 1536);
        tick(2);
        check("stream last_pulse_cycle", 32'(last_pulse_cyc), 32'(drive191_cyc + 2));
        dl_end();
        compare_run("stream");

        // Offset 4 skipped: entry 0 written, then error.
        clear_got();
        make_file(6);
        bq.delete(4);
        ioctl_download = 1'b1;
        tick(1);
        play(0, 5);
        tick(2);
        check("skip strobes_mid", got_r.size(), 32'd1);
        check("skip error_mid",   32'(er_r), 32'd1);
        check("skip loaded_mid",  32'(ld_r), 32'd0);
        dl_end();
        compare_run("skip");

        // Next download clears flags, then ends after 100 bytes.
        clear_got();
        make_file(100);
        ioctl_download = 1'b1;
        tick(1);
        check("restart error_cleared", 32'(er_r), 32'd0);
        check("restart loaded_cleared", 32'(ld_r), 32'd0);
        play(1, 100);
        tick(2);
        ioctl_download = 1'b0;
        check("short error_before_fall", 32'(er_r), 32'd0);
        tick(1);
        check("short error_after_fall", 32'(er_r), 32'd1);
        tick(2);
        compare_run("short");
        if (exp_r.size() == 33) begin
            check("short hold_index", 32'(idx_r), 32'd32);
            check("short hold_data",  32'(dat_r), 32'(exp_r[32].data));
        end

        // Reset in the middle of a download with ioctl_download held high.
        clear_got();
        make_file(192);
        ioctl_download = 1'b1;
        play(0, 50);
        reset = 1'b1;
        tick(1);
        check("midrst load_color", 32'(lc_r), 32'd0);
        check("midrst index",      32'(idx_r), 32'd0);
        check("midrst data",       32'(dat_r), 32'd0);
        check("midrst loaded",     32'(ld_r), 32'd0);
        check("midrst error",      32'(er_r), 32'd0);
        tick(1);
        reset = 1'b0;
        clear_got();
        tick(1);
        play(1, 192);
        tick(2);
        dl_end();
        compare_run("midrst");

        // Random files, gaps and occasional address faults.
        for (int t = 0; t < 8; t++) begin
            int n;
            clear_got();
            n = $urandom_range(120, 260);
            make_file(n);
            if ($urandom_range(0, 2) == 0) begin
                int p;
                p = $urandom_range(0, n - 1);
                bq[p].addr = bq[p].addr + ADDR_W'($urandom_range(1, 3));
            end
            ioctl_download = 1'b1;
            if ($urandom_range(0, 1) == 1)
                tick(1);
            play(2, n);
            tick(2);
            dl_end();
            compare_run("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
